// File: rtl/midi_parser_if.sv
// Byte-in / event-out bundle between the UART receiver, the MIDI parser and the voice allocator.
// Pitch-bend signals exist only when MIDI_PITCH_BEND_EN is defined.
interface midi_parser_if;
  logic       rx_done;
  logic [7:0] din;
  logic       note_on_valid;
  logic       note_off_valid;
  logic [6:0] note;
  logic [6:0] velocity;
  logic [3:0] channel;
  logic       cc_valid;
  logic [6:0] cc_num;
  logic [6:0] cc_val;
  logic       sync_err;
`ifdef MIDI_PITCH_BEND_EN
  logic        pb_valid;
  logic [13:0] pb_value;
`endif

  modport master (
`ifdef MIDI_PITCH_BEND_EN
    input  pb_valid, pb_value,
`endif
    output rx_done, din,
    input  note_on_valid, note_off_valid, note, velocity, channel,
    input  cc_valid, cc_num, cc_val, sync_err
  );

  modport slave (
`ifdef MIDI_PITCH_BEND_EN
    output pb_valid, pb_value,
`endif
    input  rx_done, din,
    output note_on_valid, note_off_valid, note, velocity, channel,
    output cc_valid, cc_num, cc_val, sync_err
  );
endinterface

// File: rtl/midi_parser.sv
// MIDI channel-voice decoder: running status, real-time passthrough, SysEx skipping, channel filter.
// Optional pitch-bend events are enabled by defining MIDI_PITCH_BEND_EN.
module midi_parser #(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input logic          clk,
  input logic          reset,
  midi_parser_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StD1, StD2, StSkip} state_e;

  state_e     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;

  logic       note_on_q, note_on_d;
  logic       note_off_q, note_off_d;
  logic       cc_valid_q, cc_valid_d;
  logic       sync_err_q, sync_err_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic [6:0] cc_num_q, cc_num_d;
  logic [6:0] cc_val_q, cc_val_d;
  logic [3:0] chan_q, chan_d;
`ifdef MIDI_PITCH_BEND_EN
  logic        pb_valid_q, pb_valid_d;
  logic [13:0] pb_value_q, pb_value_d;
`endif

  logic is_realtime, is_system, is_status, is_data, chan_ok;

  assign is_realtime = bus.din[7:3] == 5'b11111;
  assign is_system   = bus.din[7:3] == 5'b11110;
  assign is_status   = bus.din[7] && (bus.din[7:4] != 4'hF);
  assign is_data     = !bus.din[7];
  assign chan_ok     = OMNI || (status_q[3:0] == CHANNEL);

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    d1_d       = d1_q;
    note_on_d  = 1'b0;
    note_off_d = 1'b0;
    cc_valid_d = 1'b0;
    sync_err_d = 1'b0;
    note_d     = note_q;
    vel_d      = vel_q;
    cc_num_d   = cc_num_q;
    cc_val_d   = cc_val_q;
    chan_d     = chan_q;
`ifdef MIDI_PITCH_BEND_EN
    pb_valid_d = 1'b0;
    pb_value_d = pb_value_q;
`endif

    // Real-time bytes fall through every branch and leave all state untouched.
    if (bus.rx_done && !is_realtime) begin
      if (is_system) begin
        // F7 terminates a SysEx; data after it has no status and is reported as a sync error.
        status_d = 8'h00;
        state_d  = (bus.din == 8'hF7) ? StIdle : StSkip;
      end else if (is_status) begin
        status_d = bus.din;
        state_d  = StD1;
      end else if (is_data) begin
        unique case (state_q)
          StIdle: sync_err_d = 1'b1;
          StD1: begin
            d1_d = bus.din[6:0];
            // Cn and Dn carry a single data byte.
            if (status_q[7:5] != 3'b110) state_d = StD2;
          end
          StD2: begin
            state_d = StD1;
            if (chan_ok) begin
              case (status_q[7:4])
                4'h8, 4'h9: begin
                  if (status_q[4] && (bus.din[6:0] != 7'd0)) note_on_d = 1'b1;
                  else                                       note_off_d = 1'b1;
                  note_d = d1_q;
                  vel_d  = bus.din[6:0];
                  chan_d = status_q[3:0];
                end
                4'hB: begin
                  cc_valid_d = 1'b1;
                  cc_num_d   = d1_q;
                  cc_val_d   = bus.din[6:0];
                  chan_d     = status_q[3:0];
                end
`ifdef MIDI_PITCH_BEND_EN
                4'hE: begin
                  pb_valid_d = 1'b1;
                  pb_value_d = {bus.din[6:0], d1_q};
                  chan_d     = status_q[3:0];
                end
`endif
                default: ;
              endcase
            end
          end
          StSkip: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      status_q   <= 8'h00;
      d1_q       <= 7'd0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
      cc_valid_q <= 1'b0;
      sync_err_q <= 1'b0;
      note_q     <= 7'd0;
      vel_q      <= 7'd0;
      cc_num_q   <= 7'd0;
      cc_val_q   <= 7'd0;
      chan_q     <= 4'd0;
`ifdef MIDI_PITCH_BEND_EN
      pb_valid_q <= 1'b0;
      pb_value_q <= 14'h2000;
`endif
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      d1_q       <= d1_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      cc_valid_q <= cc_valid_d;
      sync_err_q <= sync_err_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      cc_num_q   <= cc_num_d;
      cc_val_q   <= cc_val_d;
      chan_q     <= chan_d;
`ifdef MIDI_PITCH_BEND_EN
      pb_valid_q <= pb_valid_d;
      pb_value_q <= pb_value_d;
`endif
    end
  end

  assign bus.note_on_valid  = note_on_q;
  assign bus.note_off_valid = note_off_q;
  assign bus.note           = note_q;
  assign bus.velocity       = vel_q;
  assign bus.channel        = chan_q;
  assign bus.cc_valid       = cc_valid_q;
  assign bus.cc_num         = cc_num_q;
  assign bus.cc_val         = cc_val_q;
  assign bus.sync_err       = sync_err_q;
`ifdef MIDI_PITCH_BEND_EN
  assign bus.pb_valid       = pb_valid_q;
  assign bus.pb_value       = pb_value_q;
`endif

endmodule

// File: tb/tb_midi_parser.sv
// Scoreboard bench for midi_parser: an OMNI instance and a CHANNEL=2 filtered instance.
// Expected events are queued at stimulus time and popped by per-instance monitors.
module tb_midi_parser;

  localparam int KOn = 0, KOff = 1, KCc = 2, KErr = 3, KPb = 4;

  typedef struct {
    int         kind;
    logic [6:0] a;
    logic [6:0] b;
    logic [3:0] ch;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  midi_parser_if bus_a ();
  midi_parser_if bus_b ();

  midi_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  midi_parser #(.OMNI(1'b0), .CHANNEL(4'd2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic mon(input int w, input logic on, input logic off, input logic cc,
                     input logic err, input logic pb, input logic [6:0] nt, input logic [6:0] vl,
                     input logic [6:0] cn, input logic [6:0] cv, input logic [3:0] ch,
                     input logic [13:0] pv);
    int n, kind;
    exp_t e;
    logic [6:0] x, y;
    n = int'(on) + int'(off) + int'(cc) + int'(err) + int'(pb);
    if (n == 0) return;
    chk("one_pulse", n, 1);
    kind = on ? KOn : off ? KOff : cc ? KCc : err ? KErr : KPb;
    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event dut %0d got kind %0d want none at %0t", w, kind, $time);
      return;
    end
    e = (w == 0) ? q0.pop_front() : q1.pop_front();
    chk("kind", kind, e.kind);
    chk("latency", cyc, e.cyc);
    x = (kind == KCc) ? cn : (kind == KPb) ? pv[6:0] : nt;
    y = (kind == KCc) ? cv : (kind == KPb) ? pv[13:7] : vl;
    if (kind != KErr) begin
      chk("data_a", int'(x), int'(e.a));
      chk("data_b", int'(y), int'(e.b));
      chk("channel", int'(ch), int'(e.ch));
    end
  endtask

`ifdef MIDI_PITCH_BEND_EN
  always @(negedge clk) if (!reset) begin
    mon(0, bus_a.note_on_valid, bus_a.note_off_valid, bus_a.cc_valid, bus_a.sync_err,
        bus_a.pb_valid, bus_a.note, bus_a.velocity, bus_a.cc_num, bus_a.cc_val, bus_a.channel,
        bus_a.pb_value);
    mon(1, bus_b.note_on_valid, bus_b.note_off_valid, bus_b.cc_valid, bus_b.sync_err,
        bus_b.pb_valid, bus_b.note, bus_b.velocity, bus_b.cc_num, bus_b.cc_val, bus_b.channel,
        bus_b.pb_value);
  end
`else
  always @(negedge clk) if (!reset) begin
    mon(0, bus_a.note_on_valid, bus_a.note_off_valid, bus_a.cc_valid, bus_a.sync_err, 1'b0,
        bus_a.note, bus_a.velocity, bus_a.cc_num, bus_a.cc_val, bus_a.channel, 14'h0);
    mon(1, bus_b.note_on_valid, bus_b.note_off_valid, bus_b.cc_valid, bus_b.sync_err, 1'b0,
        bus_b.note, bus_b.velocity, bus_b.cc_num, bus_b.cc_val, bus_b.channel, 14'h0);
  end
`endif

  // Drives one byte for one cycle; consecutive calls give back-to-back rx_done.
  task automatic send(input int w, input logic [7:0] b);
    @(negedge clk);
    bus_a.rx_done = (w == 0);
    bus_b.rx_done = (w == 1);
    bus_a.din     = b;
    bus_b.din     = b;
  endtask

  task automatic gap();
    @(negedge clk);
    bus_a.rx_done = 1'b0;
    bus_b.rx_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic push(input int w, input int kind, input logic [6:0] a, input logic [6:0] b,
                      input logic [3:0] ch);
    exp_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    e.ch   = ch;
    e.cyc  = cyc + 1;
    if (w == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_a.rx_done = 1'b0;
    bus_b.rx_done = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bus_a.rx_done = 1'b0;
    bus_b.rx_done = 1'b0;
    bus_a.din     = 8'h00;
    bus_b.din     = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_note_on", int'(bus_a.note_on_valid), 0);
    chk("rst_note", int'(bus_a.note), 0);
    chk("rst_velocity", int'(bus_a.velocity), 0);
    chk("rst_channel", int'(bus_a.channel), 0);
    chk("rst_cc_num", int'(bus_a.cc_num), 0);
`ifdef MIDI_PITCH_BEND_EN
    chk("rst_pb_value", int'(bus_a.pb_value), 'h2000);
`endif

    // Basic note-on
    send(0, 8'h90); send(0, 8'h3C); send(0, 8'h64); push(0, KOn, 7'h3C, 7'h64, 4'd0);
    gap();
    // Running status with velocity-0 note-off
    send(0, 8'h93); send(0, 8'h40); send(0, 8'h7F); push(0, KOn, 7'h40, 7'h7F, 4'd3);
    send(0, 8'h41); send(0, 8'h00); push(0, KOff, 7'h41, 7'h00, 4'd3);
    gap();
    // Interleaved timing clock
    send(0, 8'h90); send(0, 8'h3C); send(0, 8'hF8); send(0, 8'h64);
    push(0, KOn, 7'h3C, 7'h64, 4'd0);
    gap();
    // SysEx then orphaned data, then a controller
    send(0, 8'hF0); send(0, 8'h7E); send(0, 8'h01); send(0, 8'hF7);
    send(0, 8'h3C); push(0, KErr, 7'h0, 7'h0, 4'd0);
    send(0, 8'h64); push(0, KErr, 7'h0, 7'h0, 4'd0);
    send(0, 8'hB1); send(0, 8'h07); send(0, 8'h50); push(0, KCc, 7'h07, 7'h50, 4'd1);
    gap();
    chk("hold_note", int'(bus_a.note), 'h3C);
    chk("hold_velocity", int'(bus_a.velocity), 'h64);
    // 8n note-off, then a status byte abandoning a partial note
    send(0, 8'h80); send(0, 8'h22); send(0, 8'h33); push(0, KOff, 7'h22, 7'h33, 4'd0);
    send(0, 8'h90); send(0, 8'h11); send(0, 8'hB2); send(0, 8'h05); send(0, 8'h06);
    push(0, KCc, 7'h05, 7'h06, 4'd2);
    // One-byte program change and aftertouch produce nothing
    send(0, 8'hC5); send(0, 8'h10); send(0, 8'h11);
    send(0, 8'hA0); send(0, 8'h01); send(0, 8'h02);
    gap();
    // System common data is skipped silently
    send(0, 8'hF2); send(0, 8'h10); send(0, 8'h20); send(0, 8'h30);
    send(0, 8'h90); send(0, 8'h30); send(0, 8'h40); push(0, KOn, 7'h30, 7'h40, 4'd0);
    gap();
    // Pitch bend
`ifdef MIDI_PITCH_BEND_EN
    send(0, 8'hE0); send(0, 8'h00); send(0, 8'h40); push(0, KPb, 7'h00, 7'h40, 4'd0);
    send(0, 8'hE5); send(0, 8'h7F); send(0, 8'h7F); push(0, KPb, 7'h7F, 7'h7F, 4'd5);
`else
    send(0, 8'hE0); send(0, 8'h00); send(0, 8'h40); send(0, 8'h12); send(0, 8'h34);
`endif
    gap();

    // Channel filter on the CHANNEL=2 instance
    send(1, 8'h91); send(1, 8'h3C); send(1, 8'h64);
    gap();
    chk("filtered_note", int'(bus_b.note), 0);
    chk("filtered_channel", int'(bus_b.channel), 0);
    send(1, 8'h92); send(1, 8'h3C); send(1, 8'h64); push(1, KOn, 7'h3C, 7'h64, 4'd2);
    gap();
    // Reset mid-message
    send(1, 8'h90); send(1, 8'h3C);
    do_reset();
    chk("rst_b_note", int'(bus_b.note), 0);
    send(1, 8'h64); push(1, KErr, 7'h0, 7'h0, 4'd0);
    gap();
    // Data in idle straight after reset
    send(0, 8'h55); push(0, KErr, 7'h0, 7'h0, 4'd0);
    gap();

    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
